// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   state_e   : scan FSM states (GAP = all digits off, SCAN = one digit lit)
//   SEG_OFF   : active-low all-segments-off pattern
//   SEG_TABLE : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
package seg7_pkg;

   typedef enum logic {
      GAP  = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Element [n] is the pattern for nibble n (index 0 is the rightmost entry).
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Write port of the seven-segment scan driver (valid/ready).
//   wr_valid : source has a packed hex word to write
//   wr_data  : packed nibbles, digit d = wr_data[4d+3:4d]
//   wr_ready : sink can accept a word this cycle
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   localparam int unsigned DATA_W = 4 * NUM_DIGITS;

   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_nibble_decode.sv
// Combinational hex-nibble to active-low seven-segment lookup.
//   nibble   : 4-bit hex value
//   seg_n_c  : {g,f,e,d,c,b,a}, active low
module seg7_nibble_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n_c
);

   assign seg_n_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each slot is GAP_CYCLES all-off followed by PRESCALE cycles with one digit
// lit. New data is buffered and committed only at frame end.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   wr            : write port (seg7_scan_driver_if.slave)
//   dp            : per-digit decimal-point request, sampled live
//   blank         : force display dark (scan keeps running)
//   seg_n, dp_n   : active-low segments / decimal point
//   dig_en_n      : active-low digit enables, at most one low
//   frame_done    : one-cycle pulse after the last digit's slot
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shown).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PRESCALE   = 50000,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   seg7_scan_driver_if.slave     wr,
   input  logic [NUM_DIGITS-1:0] dp,
   input  logic                  blank,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] dig_en_n,
   output logic                  frame_done
);

   localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
   localparam int unsigned CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
   localparam int unsigned CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IDX_W   = ($clog2(NUM_DIGITS) > 0) ? $clog2(NUM_DIGITS) : 1;

   // Reject illegal parameterisations at elaboration.
   generate
      if (GAP_CYCLES < 1) begin : g_bad_gap
         $error("seg7_scan_driver: GAP_CYCLES must be >= 1");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("seg7_scan_driver: PRESCALE must be >= 1");
      end
      if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_digits
         $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
      end
   endgenerate

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]     display_q, display_d;
   logic [DATA_W-1:0]     pend_buf_q, pend_buf_d;
   logic                  pending_q, pending_d;
   logic                  wr_ready_q, wr_ready_d;
   logic [6:0]            seg_n_q, seg_n_d;
   logic                  dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
   logic                  frame_done_q, frame_done_d;

   logic [3:0]            nib_sel;
   logic [6:0]            dec_seg;
   logic [NUM_DIGITS-1:0] lead_zero;

   // Digits that are leading zeros of the committed value.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic zero_above;
      lead_zero  = '0;
      zero_above = 1'b1;
      for (int d = int'(NUM_DIGITS) - 1; d > 0; d--) begin
         zero_above   = zero_above & (display_q[4*d +: 4] == 4'h0);
         lead_zero[d] = zero_above;
      end
   end
`else
   assign lead_zero = '0;
`endif

   seg7_nibble_decode u_decode (
      .nibble  (nib_sel),
      .seg_n_c (dec_seg)
   );

   // Next-state: scan counters, write handshake, frame commit and outputs.
   always_comb begin
      logic frame_end;
      logic dp_sel;
      logic lz_sel;

      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      display_d    = display_q;
      pend_buf_d   = pend_buf_q;
      pending_d    = pending_q;
      frame_end    = 1'b0;
      nib_sel      = 4'h0;
      dp_sel       = 1'b0;
      lz_sel       = 1'b0;
      seg_n_d      = SEG_OFF;
      dp_n_d       = 1'b1;
      dig_en_n_d   = '1;

      case (state_q)
         GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               state_d = SCAN;
               cnt_d   = '0;
            end
         end
         SCAN: begin
            if (cnt_q == CNT_W'(PRESCALE - 1)) begin
               state_d = GAP;
               cnt_d   = '0;
               if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                  idx_d     = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = GAP;
            cnt_d   = '0;
         end
      endcase

      // Commit first; a write on this same edge only fills the now-free buffer.
      if (frame_end && pending_q) begin
         display_d = pend_buf_q;
         pending_d = 1'b0;
      end
      if (wr.wr_valid && wr_ready_q) begin
         pend_buf_d = wr.wr_data;
         pending_d  = 1'b1;
      end

      wr_ready_d   = ~pending_d;
      frame_done_d = frame_end;

      // Outputs follow the next state so they change on the same edge.
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         if (idx_d == IDX_W'(d)) begin
            nib_sel = display_q[4*d +: 4];
            dp_sel  = dp[d];
            lz_sel  = lead_zero[d];
         end
      end
      if ((state_d == SCAN) && !blank) begin
         for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (idx_d == IDX_W'(d)) dig_en_n_d[d] = 1'b0;
         end
         seg_n_d = lz_sel ? SEG_OFF : dec_seg;
         dp_n_d  = ~dp_sel;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= GAP;
         cnt_q        <= '0;
         idx_q        <= '0;
         display_q    <= '0;
         pend_buf_q   <= '0;
         pending_q    <= 1'b0;
         wr_ready_q   <= 1'b1;
         seg_n_q      <= SEG_OFF;
         dp_n_q       <= 1'b1;
         dig_en_n_q   <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         display_q    <= display_d;
         pend_buf_q   <= pend_buf_d;
         pending_q    <= pending_d;
         wr_ready_q   <= wr_ready_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         dig_en_n_q   <= dig_en_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr.wr_ready = wr_ready_q;
   assign seg_n       = seg_n_q;
   assign dp_n        = dp_n_q;
   assign dig_en_n    = dig_en_n_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NUM_DIGITS=4, PRESCALE=4, GAP_CYCLES=1).
// Slot = 5 cycles, frame = 20 cycles; after edge k of a frame starting at 0,
// digit d is lit at edges 5d+1 .. 5d+4 and frame_done follows edge 20.
// Honors SEG7_LEADING_ZERO_BLANK_EN for the leading-zero expectations.
module tb_seg7_scan_driver;

   localparam int unsigned ND    = 4;
   localparam int unsigned PS    = 4;
   localparam int unsigned GC    = 1;
   localparam int unsigned FRAME = ND * (GC + PS);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [ND-1:0] dp;
   logic          blank;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [ND-1:0] dig_en_n;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) wr_if ();

   seg7_scan_driver #(
      .NUM_DIGITS (ND),
      .PRESCALE   (PS),
      .GAP_CYCLES (GC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr         (wr_if.slave),
      .dp         (dp),
      .blank      (blank),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .dig_en_n   (dig_en_n),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and sample 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Step until frame_done is seen, bounded by two frames.
   task automatic wait_frame(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 2 * int'(FRAME); i++) begin
         step(1);
         if (frame_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   logic [6:0]  exp_tab [16];
   logic [15:0] sweep_words [4];
   logic [6:0]  lz_seg;
   logic [3:0]  en_exp;
   logic        seen;

   initial begin
      exp_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      sweep_words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz_seg = 7'h7F;
`else
      lz_seg = 7'h40;
`endif

      reset_n        = 1'b0;
      dp             = '0;
      blank          = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;

      // Reset values
      step(3);
      check("rst_seg", seg_n, 7'h7F);
      check("rst_en", dig_en_n, 4'hF);
      check("rst_ready", wr_if.wr_ready, 1'b1);
      check("rst_fd", frame_done, 1'b0);
      check("rst_dp", dp_n, 1'b1);

      @(negedge clk);
      reset_n = 1'b1;
      step(1);                                   // edge 1
      check("e1_en", dig_en_n, 4'hE);
      check("e1_seg", seg_n, 7'h40);

      // Write 1234 accepted at edge 2; second write while pending is ignored
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h1234;
      step(1);                                   // edge 2
      wr_if.wr_data  = 16'hABCD;
      check("e2_ready", wr_if.wr_ready, 1'b0);
      step(1);                                   // edge 3
      check("e3_ready", wr_if.wr_ready, 1'b0);
      step(2);                                   // edge 5
      wr_if.wr_valid = 1'b0;
      check("e5_gap_en", dig_en_n, 4'hF);
      check("e5_gap_seg", seg_n, 7'h7F);
      step(1);                                   // edge 6
      check("e6_en", dig_en_n, 4'hD);
      check("e6_seg_old", seg_n, 7'h40);
      step(13);                                  // edge 19
      check("e19_fd", frame_done, 1'b0);
      check("e19_ready", wr_if.wr_ready, 1'b0);
      step(1);                                   // edge 20
      check("e20_fd", frame_done, 1'b1);
      check("e20_ready", wr_if.wr_ready, 1'b1);
      check("e20_en", dig_en_n, 4'hF);
      step(1);                                   // edge 21
      check("e21_fd", frame_done, 1'b0);
      check("e21_en", dig_en_n, 4'hE);
      check("e21_seg", seg_n, 7'h19);
      step(5);                                   // edge 26
      check("e26_en", dig_en_n, 4'hD);
      check("e26_seg", seg_n, 7'h30);
      dp = 4'b0100;
      step(5);                                   // edge 31
      check("e31_en", dig_en_n, 4'hB);
      check("e31_seg", seg_n, 7'h24);
      check("e31_dp", dp_n, 1'b0);
      dp = 4'b0000;
      step(5);                                   // edge 36
      check("e36_en", dig_en_n, 4'h7);
      check("e36_seg", seg_n, 7'h79);
      check("e36_dp", dp_n, 1'b1);

      // Write accepted on the frame-end edge itself commits one frame later
      step(3);                                   // edge 39
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h5678;
      step(1);                                   // edge 40
      wr_if.wr_valid = 1'b0;
      check("e40_fd", frame_done, 1'b1);
      check("e40_ready", wr_if.wr_ready, 1'b0);
      step(1);                                   // edge 41
      check("e41_seg_old", seg_n, 7'h19);
      step(19);                                  // edge 60
      check("e60_fd", frame_done, 1'b1);
      check("e60_ready", wr_if.wr_ready, 1'b1);
      step(1);                                   // edge 61
      check("e61_seg", seg_n, 7'h00);

      // Blank mid-SCAN; counters and handshake keep running
      step(1);                                   // edge 62
      blank = 1'b1;
      step(1);                                   // edge 63
      check("blank_seg", seg_n, 7'h7F);
      check("blank_en", dig_en_n, 4'hF);
      check("blank_dp", dp_n, 1'b1);
      step(17);                                  // edge 80
      check("blank_fd80", frame_done, 1'b1);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h00F0;
      step(1);                                   // edge 81
      wr_if.wr_valid = 1'b0;
      check("blank_wr_ready", wr_if.wr_ready, 1'b0);
      check("blank_en81", dig_en_n, 4'hF);
      step(19);                                  // edge 100
      check("blank_fd100", frame_done, 1'b1);
      blank = 1'b0;
      step(1);                                   // edge 101
      check("lz_d0_en", dig_en_n, 4'hE);
      check("lz_d0_seg", seg_n, 7'h40);
      step(5);                                   // edge 106
      check("lz_d1_seg", seg_n, 7'h0E);
      step(5);                                   // edge 111
      check("lz_d2_en", dig_en_n, 4'hB);
      check("lz_d2_seg", seg_n, lz_seg);
      step(5);                                   // edge 116
      check("lz_d3_en", dig_en_n, 4'h7);
      check("lz_d3_seg", seg_n, lz_seg);

      // Mid-frame reset with a write pending discards it
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h9999;
      step(1);                                   // edge 117
      wr_if.wr_valid = 1'b0;
      check("pre_rst_ready", wr_if.wr_ready, 1'b0);
      step(1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_seg", seg_n, 7'h7F);
      check("mid_rst_en", dig_en_n, 4'hF);
      check("mid_rst_ready", wr_if.wr_ready, 1'b1);
      check("mid_rst_fd", frame_done, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1);                                   // edge 1
      check("post_rst_en", dig_en_n, 4'hE);
      check("post_rst_seg", seg_n, 7'h40);
      step(19);                                  // edge 20
      check("post_rst_fd", frame_done, 1'b1);
      step(1);                                   // edge 21
      check("post_rst_discard", seg_n, 7'h40);

      // Decode sweep of all 16 nibbles, four digits per write
      for (int w = 0; w < 4; w++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_data  = sweep_words[w];
         step(1);
         wr_if.wr_valid = 1'b0;
         wait_frame(seen);
         check($sformatf("sweep%0d_frame", w), seen, 1'b1);
         for (int d = 0; d < int'(ND); d++) begin
            step((d == 0) ? 1 : int'(GC + PS));
            en_exp    = 4'hF;
            en_exp[d] = 1'b0;
            check($sformatf("sweep%0d_d%0d_en", w, d), dig_en_n, en_exp);
            check($sformatf("sweep%0d_d%0d_seg", w, d), seg_n, exp_tab[4*w + d]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Takes a packed hex word through a valid/ready write port and scans digits one at a time.
- Inserts an all-off gap between digits to prevent ghosting.
- Commits new display data only at frame boundaries, so a frame never shows a mixed old/new value; sits between CPU/game-state logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clk cycles each digit is lit per slot (>=1).
- GAP_CYCLES, 16, clk cycles all digits are off before each slot (>=1; a value of 0 is an elaboration error).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_data  in  4*NUM_DIGITS  packed nibbles; digit d = wr_data[4d+3:4d], digit 0 least significant
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a rising edge
- dp  in  NUM_DIGITS  decimal-point request per digit, sampled live
- blank  in  1  force display dark
- seg_n  out  7  {g,f,e,d,c,b,a}, active low
- dp_n  out  1  decimal point, active low
- dig_en_n  out  NUM_DIGITS  digit enables, active low, at most one low
- frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset, asynchronous on reset_n low:
  - Outputs: seg_n=7'h7F, dp_n=1, dig_en_n=all 1, frame_done=0, wr_ready=1.
  - Internal: display register=0, pending flag=0, state=GAP, cnt=0, idx=0.
  - Mid-operation reset aborts the scan and discards any pending data.
- FSM, two states, per slot:
  - GAP: all digits off. cnt counts 0..GAP_CYCLES-1; on the last count, go to SCAN with cnt=0.
  - SCAN: dig_en_n[idx]=0. cnt counts 0..PRESCALE-1; on the last count, go to GAP with cnt=0 and idx=(idx+1) mod NUM_DIGITS.
- Timing:
  - Cycle k means the k-th rising edge after reset_n deasserts.
  - Digit 0 is lit from edge GAP_CYCLES for exactly PRESCALE cycles.
  - Frame length = NUM_DIGITS*(GAP_CYCLES+PRESCALE) cycles.
- All outputs are registered and aligned with the state: dig_en_n, seg_n and dp_n change on the same edge as the state change.
- In SCAN: seg_n = decode(display[idx]) and dp_n = ~dp[idx]. In GAP: seg_n=7'h7F and dp_n=1.
- frame_done = 1 for the single cycle following the edge where SCAN of idx=NUM_DIGITS-1 completes.
- Write handshake:
  - wr_ready = ~pending.
  - An accepted write loads the pending buffer; pending=1 and wr_ready=0 from the next cycle.
  - At the frame-end edge (the same edge that raises frame_done): if pending, display<=pending buffer and pending<=0, so wr_ready returns 1 the following cycle.
- Boundary cases:
  - Write accepted on the frame-end edge itself: captured into pending and committed at the NEXT frame end. No bypass.
  - wr_valid while wr_ready=0: ignored; data held by the source.
- blank=1:
  - Registered; from the next edge, seg_n=7'h7F, dp_n=1 and dig_en_n all 1.
  - Scan counters keep running and frame_done still pulses; writes still accepted.
- Decode is pure lookup. No arithmetic beyond the counters; counter widths are $clog2 of their maximum value, and idx wraps modulo NUM_DIGITS, including non-power-of-two values.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- With the macro defined: a digit d>0 whose nibble is 0 and all of whose more-significant nibbles are 0 outputs seg_n=7'h7F (dp_n still follows dp). Digit 0 always displays, so value 0 shows "0".
- Without the macro: every digit displays its nibble, leading zeros included.

Decomposition:
- Package seg7_pkg holds:
  - state enum {GAP, SCAN};
  - SEG_OFF=7'h7F;
  - 16-entry active-low pattern table, 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- One combinational sub-module, seg7_nibble_decode (4-bit nibble in, 7-bit seg_n out, table lookup).
- FSM, counters, handshake and blanking stay in seg7_scan_driver.

Test Plan (NUM_DIGITS=4, PRESCALE=4, GAP_CYCLES=1 unless stated):
- Reset: hold reset_n=0 -> seg_n=7F, dig_en_n=F, wr_ready=1, frame_done=0. Release -> digit 0 lit at edge 1 with seg_n=40 ("0").
- Write 16'h1234 at cycle 2 -> wr_ready=0 from cycle 3; frame_done at edge 20; then digits 0..3 show 19,30,24,79; wr_ready=1 at edge 21.
- Second write while pending -> not accepted, pending data unchanged. Write on the frame-end edge -> shown only after the following frame (edge 40).
- blank=1 mid-SCAN -> next edge seg_n=7F, dig_en_n=F; frame_done keeps pulsing every 20 cycles.
- Assert reset_n=0 mid-frame with write pending -> immediate reset values; display shows 0000 after release.
- SEG7_LEADING_ZERO_BLANK_EN defined, write 16'h0070 -> digits 3,2 = 7F, digit 1 = 78, digit 0 = 40. Sweep nibbles 0..F -> table match.
